// File: rtl/imem_loader_pkg.sv
// imem_pkg: shared constants, FSM state type and address helper for the instruction-memory loader
package imem_pkg;
  localparam int ADDR_W = 10;
  localparam int WORD_W = 32;
  localparam int BYTES_PER_WORD = 4;
  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, CHECK} state_t;
  function automatic logic [ADDR_W-1:0] word_to_byte_addr(input logic [ADDR_W-3:0] idx);
    return {idx, 2'b00};
  endfunction
endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: little-endian byte-to-word assembler with a pulse on the byte that completes a word
module byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        accept,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_ready
);
  import imem_pkg::*;
  logic [1:0] cnt;
  logic [WORD_W-1:0] acc;
  // word already includes the byte being accepted, so the top can latch it on word_ready
  always_comb begin
    word = acc;
    word[8*cnt +: 8] = byte_data;
  end
  assign word_ready = accept && cnt == 2'(BYTES_PER_WORD-1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      acc <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= cnt + 1'b1;
      acc <= word;
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: packs a byte stream into 32-bit instruction-memory writes; IMEM_LOADER_CHECKSUM_EN adds a trailing checksum byte
module imem_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH_WORDS = 2**(ADDR_W-2)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-2:0] num_words,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold
);
  import imem_pkg::*;
  localparam int NW = ADDR_W-1;
  state_t state;
  logic [NW-1:0] nw;
  logic [ADDR_W-3:0] widx;
  logic [31:0] pk_word;
  logic pk_ready, accept, last, go;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] sum;
`endif
  assign byte_ready = state == RECV || state == CHECK;
  assign accept = byte_valid && state == RECV;
  assign mem_we = state == WRITE;
  assign busy = state == RECV || state == WRITE;
  assign cpu_hold = busy;
  assign last = {1'b0, widx} == nw - 1'b1;
  assign go = start && (state == IDLE || state == DONE);
  byte_packer u_pack (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (go),
    .accept     (accept),
    .byte_data  (byte_data),
    .word       (pk_word),
    .word_ready (pk_ready)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      nw <= '0;
      widx <= '0;
      done <= 1'b0;
      error <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          done <= 1'b0;
          error <= 1'b0;
          nw <= num_words;
          widx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum <= '0;
`endif
          if (num_words > NW'(DEPTH_WORDS)) begin
            error <= 1'b1;
            done <= 1'b1;
            state <= DONE;
          end else if (num_words == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state <= CHECK;
`else
            done <= 1'b1;
            state <= DONE;
`endif
          end else begin
            state <= RECV;
          end
        end
        RECV: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (accept) sum <= sum + byte_data;
`endif
          if (pk_ready) begin
            mem_addr <= word_to_byte_addr(widx);
            mem_wdata <= pk_word;
            state <= WRITE;
          end
        end
        WRITE: if (last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state <= CHECK;
`else
          done <= 1'b1;
          state <= DONE;
`endif
        end else begin
          widx <= widx + 1'b1;
          state <= RECV;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK: if (byte_valid) begin
          error <= byte_data != sum;
          done <= 1'b1;
          state <= DONE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven directed test of the instruction-memory loader
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst_n, start, byte_valid, byte_ready, mem_we, busy, done, error, cpu_hold;
  logic [8:0] num_words;
  logic [7:0] byte_data;
  logic [9:0] mem_addr;
  logic [31:0] mem_wdata;
  int checks = 0, failures = 0, wr_total = 0, hold_bad = 0;
  logic [9:0] wr_addr [64];
  logic [31:0] wr_data [64];
  logic [47:0] outs;
  assign outs = {byte_ready, mem_we, mem_addr, mem_wdata, busy, done, error, cpu_hold};
  always #5 clk = ~clk;
  imem_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_words  (num_words),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .cpu_hold   (cpu_hold)
  );
  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr[wr_total % 64] = mem_addr;
      wr_data[wr_total % 64] = mem_wdata;
      wr_total++;
      if (!cpu_hold) hold_bad++;
    end
    if (cpu_hold !== busy) hold_bad++;
  end
  typedef struct packed {
    logic [8:0]  nw;
    int          n;
    logic [63:0] b;
    bit          tog;
    int          mid;
    bit          bad;
    int          en;
    logic [31:0] d0;
    logic [31:0] d1;
    bit          err;
  } vec_t;
  vec_t vecs [8];
  function automatic vec_t mk(input logic [8:0] nw, input int n, input logic [63:0] b, input bit tog,
                              input int mid, input bit bad, input int en, input logic [31:0] d0,
                              input logic [31:0] d1, input bit err);
    vec_t v;
    v.nw = nw; v.n = n; v.b = b; v.tog = tog; v.mid = mid; v.bad = bad;
    v.en = en; v.d0 = d0; v.d1 = d1; v.err = err;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask
  task automatic run_load(input vec_t v, input string nm);
    int base, i, n;
    logic [7:0] sum;
    logic [71:0] s;
    bit pulsed;
    base = wr_total;
    n = v.n;
    s = {8'h00, v.b};
    sum = 8'h00;
    for (int k = 0; k < n; k++) sum = sum + s[8*k +: 8];
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (v.nw <= 9'd256) begin
      s[8*n +: 8] = sum + 8'(v.bad);
      n++;
    end
`endif
    @(negedge clk);
    start = 1'b1;
    num_words = v.nw;
    @(negedge clk);
    start = 1'b0;
`ifndef IMEM_LOADER_CHECKSUM_EN
    if (v.nw == 9'd0) chk({nm, "_done_next"}, done, 1'b1);
`endif
    if (v.nw > 9'd256) chk({nm, "_err_next"}, {done, error}, 2'b11);
    i = 0;
    pulsed = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      start = (i == v.mid) && !pulsed;
      if (start) begin
        pulsed = 1'b1;
        num_words = 9'd5;
      end
      byte_valid = (i < n) && (!v.tog || c[0]);
      byte_data = (i < n) ? s[8*i +: 8] : 8'h00;
      if (byte_valid && byte_ready) i++;
      @(negedge clk);
    end
    start = 1'b0;
    byte_valid = 1'b0;
    chk({nm, "_done"}, done, 1'b1);
    chk({nm, "_error"}, error, v.err);
    chk({nm, "_busy"}, busy, 1'b0);
    chk({nm, "_nwrites"}, wr_total - base, v.en);
    for (int k = 0; k < v.en; k++) begin
      chk($sformatf("%s_addr%0d", nm, k), wr_addr[(base + k) % 64], 10'(4 * k));
      chk($sformatf("%s_data%0d", nm, k), wr_data[(base + k) % 64], k == 0 ? v.d0 : v.d1);
    end
  endtask
  initial begin
    int base, k;
    logic [63:0] pl;
    bit cks;
`ifdef IMEM_LOADER_CHECKSUM_EN
    cks = 1'b1;
`else
    cks = 1'b0;
`endif
    vecs[0] = mk(9'd2, 8, 64'h00100093_00000013, 1'b0, -1, 1'b0, 2, 32'h00000013, 32'h00100093, 1'b0);
    vecs[1] = mk(9'd2, 8, 64'h00100093_00000013, 1'b1, -1, 1'b0, 2, 32'h00000013, 32'h00100093, 1'b0);
    vecs[2] = mk(9'd2, 8, 64'h00100093_00000013, 1'b0, 2, 1'b0, 2, 32'h00000013, 32'h00100093, 1'b0);
    vecs[3] = mk(9'd0, 0, 64'h0, 1'b0, -1, 1'b0, 0, 32'h0, 32'h0, 1'b0);
    vecs[4] = mk(9'd257, 0, 64'h0, 1'b0, -1, 1'b0, 0, 32'h0, 32'h0, 1'b1);
    vecs[5] = mk(9'd1, 4, 64'hDEADBEEF, 1'b0, -1, 1'b0, 1, 32'hDEADBEEF, 32'h0, 1'b0);
    vecs[6] = mk(9'd1, 4, 64'h04030201, 1'b0, -1, 1'b0, 1, 32'h04030201, 32'h0, 1'b0);
    vecs[7] = mk(9'd1, 4, 64'h04030201, 1'b0, -1, 1'b1, 1, 32'h04030201, 32'h0, cks);
    rst_n = 1'b0;
    start = 1'b0;
    num_words = '0;
    byte_valid = 1'b0;
    byte_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs, 48'h0);
    rst_n = 1'b1;
    for (int v = 0; v < 5; v++) run_load(vecs[v], $sformatf("v%0d", v));
    // restart from DONE (with error set), then reset after two bytes of word 1
    base = wr_total;
    pl = 64'h00100093_00000013;
    start = 1'b1;
    num_words = 9'd2;
    @(negedge clk);
    start = 1'b0;
    chk("restart_flags", {done, error, busy}, 3'b001);
    k = 0;
    for (int c = 0; c < 50 && k < 6; c++) begin
      byte_valid = 1'b1;
      byte_data = pl[8*k +: 8];
      if (byte_ready) k++;
      @(negedge clk);
    end
    byte_valid = 1'b0;
    chk("partial_nwrites", wr_total - base, 1);
    chk("partial_data0", wr_data[base % 64], 32'h00000013);
    chk("partial_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("midload_reset", outs, 48'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int v = 5; v < 8; v++) run_load(vecs[v], $sformatf("v%0d", v));
    chk("hold_tracking", hold_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
